arp_rx: RTL and testbench
=========================

# arp_rx

GMII receive-side companion to the ARP request sender on PHY#1. Consumes the byte stream from the PHY's RX interface, strips and validates the preamble/SFD, checks the Ethernet FCS, and parses ARP frames addressed to this station. A valid ARP request or reply produces a one-cycle strobe carrying the peer's MAC/IP. It also keeps frame and CRC-error statistics for LED/debug use.

## Interface

- MY_MAC, 48'h00301ba0a48e, station MAC address; unicast destination match
- MY_IP, 32'h0a00150a, station IPv4 address (10.0.21.10); ARP target protocol address match
- phy1_rx_clk  in  1  PHY receive clock, 125 MHz; the only clock
- reset_n  in  1  asynchronous, active-low reset
- phy1_rx_dv  in  1  GMII receive data valid
- phy1_rx_data  in  8  GMII receive byte
- arp_valid  out  1  one-cycle strobe: accepted ARP frame
- arp_is_request  out  1  1 = opcode 1 (request), 0 = opcode 2 (reply); held with the address outputs
- arp_sender_mac  out  48  sender hardware address, held until the next arp_valid
- arp_sender_ip  out  32  sender protocol address, held until the next arp_valid
- frame_cnt  out  16  frames that reached end-of-frame in DATA; saturating
- crc_err_cnt  out  16  frames failing the FCS check; saturating

## Operation

- Reset clears all outputs and counters to 0, clears all captured fields, and puts the FSM in IDLE.
- FSM states:
  - IDLE
    - dv=1 with byte 0x55: go to PRE.
    - dv=1 with any other byte: go to DROP.
  - PRE
    - 0x55: stay.
    - 0xD5: go to DATA, clear the byte offset, and initialise the CRC.
    - Other byte: go to DROP.
    - dv=0: go to IDLE.
  - DATA
    - Each dv=1 byte is fed to the CRC, captured at its offset, and increments an 11-bit offset.
    - dv=0 is end-of-frame (EOF): evaluate the frame, then go to IDLE.
    - Offset reaching 1518 with dv still 1: go to DROP (no count, no strobe).
  - DROP
    - Wait for dv=0, then go to IDLE.
    - No counters change.
- Byte offsets after the SFD:
  - dst MAC 0–5, src MAC 6–11, ethertype 12–13
  - htype 14–15, ptype 16–17, hlen 18, plen 19, oper 20–21
  - SHA 22–27, SPA 28–31, THA 32–37, TPA 38–41
  - FCS is the last 4 bytes.
- Field checks:
  - Bytes are compared to their constants on the fly into sticky per-field mismatch flags.
  - SHA and SPA are shifted into holding registers.
- Frame is accepted at EOF only if all of the following hold:
  - byte count is in 64..1518 inclusive
  - CRC residue equals 32'hC704DD7B
  - dst is FF:FF:FF:FF:FF:FF or MY_MAC
  - ethertype is 0x0806
  - htype is 1, ptype is 0x0800, hlen is 6, plen is 4
  - oper is 1 or 2
  - TPA equals MY_IP
- Statistics at EOF:
  - frame_cnt increments on every EOF from DATA, regardless of length or content.
  - crc_err_cnt increments when the residue is wrong and byte count ≥ 64.
  - Runts (< 64 bytes) are counted in frame_cnt only.
  - Both counters saturate at 16'hFFFF.

## Timing

- EOF cycle: the first rising edge of phy1_rx_clk where dv=0 while in DATA.
  - arp_valid is registered high for exactly the cycle following that edge.
  - arp_sender_mac, arp_sender_ip and arp_is_request update on the same edge.
  - Counters update on the same edge.
- The CRC is updated combinationally with the byte and registered, so the residue is final at the EOF edge. There are no bubbles.
- Back-to-back frames: a new 0x55 can arrive the cycle after EOF. The FSM is in IDLE by then and must accept it; the minimum IFG is not enforced.
- dv dropping in PRE or DROP never strobes or counts.
- Asynchronous reset mid-frame:
  - State and outputs clear immediately.
  - If dv is still 1 when reset releases, the first byte is judged by the IDLE rule. A mid-frame byte is not 0x55, so the FSM goes to DROP and the partial frame is discarded.

## Structure

- Shared package `eth_pkg`:
  - ETH_PREAMBLE 8'h55, ETH_SFD 8'hD5
  - ETHERTYPE_ARP 16'h0806, ETHERTYPE_IPV4 16'h0800
  - ARP_OPER_REQ 1, ARP_OPER_REP 2
  - ETH_MIN_LEN 64, ETH_MAX_LEN 1518
  - CRC32_RESIDUE 32'hC704DD7B
  - rx FSM state enum
- One sub-module, `crc32_d8`:
  - reflected CRC-32 (poly 0x04C11DB7), 8 bits per clock
  - inputs: init, en, data[7:0]
  - output: crc[31:0]
  - shared with the transmit side.

## Test plan

- Valid ARP reply, 60 bytes + correct FCS:
  - frame: SHA 00-11-22-33-44-55, SPA 10.0.21.99, dst MY_MAC, TPA 10.0.21.10
  - expect one arp_valid pulse, arp_sender_mac 48'h001122334455, arp_sender_ip 32'h0a001563, arp_is_request 0, frame_cnt 1, crc_err_cnt 0.
- Same frame with byte 30 flipped → no arp_valid, crc_err_cnt 1, frame_cnt 1, previous held address outputs unchanged.
- Broadcast ARP request with TPA 10.0.21.77 → no strobe, frame_cnt +1; with TPA 10.0.21.10 → strobe, arp_is_request 1.
- Preamble 55 55 54 … followed by a full frame → DROP, no counter change. 40-byte runt with valid preamble → frame_cnt +1, crc_err_cnt unchanged, no strobe.
- Two valid replies separated by a 1-cycle dv gap → two arp_valid pulses; outputs carry the second sender.
- reset_n asserted at offset 25 of a valid frame → all outputs 0. reset_n released mid-frame → partial frame discarded. Next clean frame → accepted normally.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, the receive FSM state type and a bit-reflection
// helper used by the receive and transmit paths.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [15:0] ETHERTYPE_ARP   = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
  localparam logic [7:0]  ARP_HLEN_ETH    = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4   = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ    = 16'd1;
  localparam logic [15:0] ARP_OPER_REP    = 16'd2;
  localparam logic [10:0] ETH_MIN_LEN     = 11'd64;
  localparam logic [10:0] ETH_MAX_LEN     = 11'd1518;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PRE,
    RX_DATA,
    RX_DROP
  } rx_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 (poly 0x04C11DB7), one byte per clock, LSB first.
//   clk, rst_n : clock, async active-low reset
//   init       : load all-ones seed
//   en         : fold data into the running CRC
//   data       : input byte
//   crc        : registered CRC state (reflected, not complemented)
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc;
    for (int unsigned i = 0; i < 8; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? CRC32_POLY_REFL : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= '1;
    else if (init) crc <= '1;
    else if (en)   crc <= crc_next;
  end

endmodule

// File: rtl/arp_rx.sv
// GMII receive path: preamble/SFD strip, FCS check, ARP request/reply parse.
//   phy1_rx_clk, reset_n        : clock, async active-low reset
//   phy1_rx_dv, phy1_rx_data    : GMII receive byte stream
//   arp_valid                   : one-cycle strobe for an accepted ARP frame
//   arp_is_request              : 1 = request, 0 = reply (held)
//   arp_sender_mac/ip           : peer addresses (held until next strobe)
//   frame_cnt, crc_err_cnt      : saturating statistics
module arp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC = 48'h00301ba0a48e,
  parameter logic [31:0] MY_IP  = 32'h0a00150a
) (
  input  logic        phy1_rx_clk,
  input  logic        reset_n,
  input  logic        phy1_rx_dv,
  input  logic [7:0]  phy1_rx_data,
  output logic        arp_valid,
  output logic        arp_is_request,
  output logic [47:0] arp_sender_mac,
  output logic [31:0] arp_sender_ip,
  output logic [15:0] frame_cnt,
  output logic [15:0] crc_err_cnt
);

  rx_state_e   state, state_next;
  logic [10:0] offset;
  logic        dst_bc_mis, dst_uc_mis, fld_mis;
  logic [7:0]  oper_lo;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [31:0] crc;

  logic        sfd_hit, byte_en, eof;
  logic        is_dst, is_fld;
  logic [7:0]  uc_byte, fld_byte;
  logic        len_ok, crc_ok, dst_ok, oper_ok, accept;

  assign sfd_hit = (state == RX_PRE) && phy1_rx_dv && (phy1_rx_data == ETH_SFD);
  assign byte_en = (state == RX_DATA) && phy1_rx_dv && (offset != ETH_MAX_LEN);
  assign eof     = (state == RX_DATA) && !phy1_rx_dv;

  crc32_d8 u_crc (
    .clk   (phy1_rx_clk),
    .rst_n (reset_n),
    .init  (sfd_hit),
    .en    (byte_en),
    .data  (phy1_rx_data),
    .crc   (crc)
  );

  always_ff @(posedge phy1_rx_clk or negedge reset_n) begin
    if (!reset_n) state <= RX_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:
        if (phy1_rx_dv)
          state_next = (phy1_rx_data == ETH_PREAMBLE) ? RX_PRE : RX_DROP;
      RX_PRE:
        if (!phy1_rx_dv)                      state_next = RX_IDLE;
        else if (phy1_rx_data == ETH_SFD)     state_next = RX_DATA;
        else if (phy1_rx_data != ETH_PREAMBLE) state_next = RX_DROP;
      RX_DATA:
        if (!phy1_rx_dv)                 state_next = RX_IDLE;
        else if (offset == ETH_MAX_LEN)  state_next = RX_DROP;
      RX_DROP:
        if (!phy1_rx_dv) state_next = RX_IDLE;
      default: state_next = RX_IDLE;
    endcase
  end

  // Expected constant for the byte at the current offset.
  always_comb begin
    is_dst   = 1'b0;
    uc_byte  = '0;
    is_fld   = 1'b0;
    fld_byte = '0;
    case (offset)
      11'd0:  begin is_dst = 1'b1; uc_byte = MY_MAC[47:40]; end
      11'd1:  begin is_dst = 1'b1; uc_byte = MY_MAC[39:32]; end
      11'd2:  begin is_dst = 1'b1; uc_byte = MY_MAC[31:24]; end
      11'd3:  begin is_dst = 1'b1; uc_byte = MY_MAC[23:16]; end
      11'd4:  begin is_dst = 1'b1; uc_byte = MY_MAC[15:8];  end
      11'd5:  begin is_dst = 1'b1; uc_byte = MY_MAC[7:0];   end
      11'd12: begin is_fld = 1'b1; fld_byte = ETHERTYPE_ARP[15:8];  end
      11'd13: begin is_fld = 1'b1; fld_byte = ETHERTYPE_ARP[7:0];   end
      11'd14: begin is_fld = 1'b1; fld_byte = ARP_HTYPE_ETH[15:8];  end
      11'd15: begin is_fld = 1'b1; fld_byte = ARP_HTYPE_ETH[7:0];   end
      11'd16: begin is_fld = 1'b1; fld_byte = ETHERTYPE_IPV4[15:8]; end
      11'd17: begin is_fld = 1'b1; fld_byte = ETHERTYPE_IPV4[7:0];  end
      11'd18: begin is_fld = 1'b1; fld_byte = ARP_HLEN_ETH;         end
      11'd19: begin is_fld = 1'b1; fld_byte = ARP_PLEN_IPV4;        end
      11'd20: begin is_fld = 1'b1; fld_byte = ARP_OPER_REQ[15:8];   end
      11'd38: begin is_fld = 1'b1; fld_byte = MY_IP[31:24]; end
      11'd39: begin is_fld = 1'b1; fld_byte = MY_IP[23:16]; end
      11'd40: begin is_fld = 1'b1; fld_byte = MY_IP[15:8];  end
      11'd41: begin is_fld = 1'b1; fld_byte = MY_IP[7:0];   end
      default: ;
    endcase
  end

  // Upper bound is implied: offset cannot pass ETH_MAX_LEN while in DATA.
  assign len_ok  = (offset >= ETH_MIN_LEN);
  // Register holds the reflected CRC; the residue constant is MSB-first.
  assign crc_ok  = (reflect32(crc) == CRC32_RESIDUE);
  assign dst_ok  = !dst_bc_mis || !dst_uc_mis;
  assign oper_ok = (oper_lo == ARP_OPER_REQ[7:0]) || (oper_lo == ARP_OPER_REP[7:0]);
  assign accept  = len_ok && crc_ok && dst_ok && !fld_mis && oper_ok;

  always_ff @(posedge phy1_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      offset         <= '0;
      dst_bc_mis     <= 1'b0;
      dst_uc_mis     <= 1'b0;
      fld_mis        <= 1'b0;
      oper_lo        <= '0;
      sha            <= '0;
      spa            <= '0;
      arp_valid      <= 1'b0;
      arp_is_request <= 1'b0;
      arp_sender_mac <= '0;
      arp_sender_ip  <= '0;
      frame_cnt      <= '0;
      crc_err_cnt    <= '0;
    end else begin
      arp_valid <= 1'b0;
      if (sfd_hit) begin
        offset     <= '0;
        dst_bc_mis <= 1'b0;
        dst_uc_mis <= 1'b0;
        fld_mis    <= 1'b0;
      end
      if (byte_en) begin
        offset <= offset + 11'd1;
        if (is_dst && phy1_rx_data != 8'hFF)    dst_bc_mis <= 1'b1;
        if (is_dst && phy1_rx_data != uc_byte)  dst_uc_mis <= 1'b1;
        if (is_fld && phy1_rx_data != fld_byte) fld_mis    <= 1'b1;
        if (offset == 11'd21) oper_lo <= phy1_rx_data;
        if (offset >= 11'd22 && offset <= 11'd27) sha <= {sha[39:0], phy1_rx_data};
        if (offset >= 11'd28 && offset <= 11'd31) spa <= {spa[23:0], phy1_rx_data};
      end
      if (eof) begin
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
        if (len_ok && !crc_ok && crc_err_cnt != '1) crc_err_cnt <= crc_err_cnt + 16'd1;
        if (accept) begin
          arp_valid      <= 1'b1;
          arp_is_request <= (oper_lo == ARP_OPER_REQ[7:0]);
          arp_sender_mac <= sha;
          arp_sender_ip  <= spa;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
module tb_arp_rx;

  localparam logic [47:0] MY_MAC = 48'h00301ba0a48e;
  localparam logic [31:0] MY_IP  = 32'h0a00150a;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        arp_valid, arp_is_request;
  logic [47:0] arp_sender_mac;
  logic [31:0] arp_sender_ip;
  logic [15:0] frame_cnt, crc_err_cnt;

  arp_rx #(.MY_MAC(MY_MAC), .MY_IP(MY_IP)) dut (
    .phy1_rx_clk    (clk),
    .reset_n        (reset_n),
    .phy1_rx_dv     (dv),
    .phy1_rx_data   (data),
    .arp_valid      (arp_valid),
    .arp_is_request (arp_is_request),
    .arp_sender_mac (arp_sender_mac),
    .arp_sender_ip  (arp_sender_ip),
    .frame_cnt      (frame_cnt),
    .crc_err_cnt    (crc_err_cnt)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic        req;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [7:0]  frm[$];
  logic [31:0] crc_tab [256];

  // Reference model state
  logic [15:0] m_frames = '0, m_crcerr = '0;
  logic [47:0] m_mac = '0;
  logic [31:0] m_ip = '0;
  logic        m_req = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest predicted ARP event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && arp_valid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got mac %h ip %h req %b, expected no strobe",
                   arp_sender_mac, arp_sender_ip, arp_is_request);
        end else begin
          e = sbq.pop_front();
          if ({arp_sender_mac, arp_sender_ip, arp_is_request} !== e) begin
            errors++;
            $display("FAIL strobe_fields: got mac %h ip %h req %b, expected mac %h ip %h req %b",
                     arp_sender_mac, arp_sender_ip, arp_is_request, e.mac, e.ip, e.req);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) c = crc_tab[c[7:0] ^ frm[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic put(input logic [47:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] oper,
                       input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                       input int total);
    logic [31:0] f;
    frm.delete();
    put(dst, 6); put(48'h020000000001, 6); put(48'(et), 2);
    put(48'h0001, 2); put(48'h0800, 2); put(48'h06, 1); put(48'h04, 1);
    put(48'(oper), 2); put(sha, 6); put(48'(spa), 4); put(48'h0, 6); put(48'(tpa), 4);
    while (frm.size() < total - 4) frm.push_back(8'h00);
    while (frm.size() > total - 4) void'(frm.pop_back());
    f = fcs_of(total - 4);
    frm.push_back(f[7:0]); frm.push_back(f[15:8]);
    frm.push_back(f[23:16]); frm.push_back(f[31:24]);
  endtask

  // Frame-level prediction from the byte array currently in frm.
  task automatic predict(input int bad_pre);
    int n;
    logic crc_ok, acc;
    logic [47:0] dst, sha;
    logic [31:0] spa, tpa;
    logic [15:0] et, ht, pt, op;
    n = frm.size();
    if (bad_pre != 0 || n > 1518) return;
    if (m_frames != 16'hFFFF) m_frames++;
    crc_ok = 1'b0;
    if (n >= 4) crc_ok = (fcs_of(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    if (n >= 64 && !crc_ok && m_crcerr != 16'hFFFF) m_crcerr++;
    if (n < 64) return;
    dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    et  = {frm[12], frm[13]};
    ht  = {frm[14], frm[15]};
    pt  = {frm[16], frm[17]};
    op  = {frm[20], frm[21]};
    sha = {frm[22], frm[23], frm[24], frm[25], frm[26], frm[27]};
    spa = {frm[28], frm[29], frm[30], frm[31]};
    tpa = {frm[38], frm[39], frm[40], frm[41]};
    acc = crc_ok && (dst == BCAST || dst == MY_MAC) && et == 16'h0806 && ht == 16'd1 &&
          pt == 16'h0800 && frm[18] == 8'd6 && frm[19] == 8'd4 &&
          (op == 16'd1 || op == 16'd2) && tpa == MY_IP;
    if (acc) begin
      m_mac = sha; m_ip = spa; m_req = (op == 16'd1);
      sbq.push_back('{mac: sha, ip: spa, req: (op == 16'd1)});
    end
  endtask

  task automatic drive(input logic d, input logic [7:0] b);
    @(negedge clk);
    dv = d;
    data = b;
  endtask

  task automatic send(input int bad_pre, input int gap);
    predict(bad_pre);
    if (bad_pre != 0) begin
      drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'h54);
      repeat (4) drive(1'b1, 8'h55);
    end else begin
      repeat (7) drive(1'b1, 8'h55);
    end
    drive(1'b1, 8'hD5);
    foreach (frm[i]) drive(1'b1, frm[i]);
    repeat (gap) drive(1'b0, 8'($urandom));
  endtask

  task automatic check_state(input string tag);
    #1;
    check({tag, "_frame_cnt"},   80'(frame_cnt),      80'(m_frames));
    check({tag, "_crc_err_cnt"}, 80'(crc_err_cnt),    80'(m_crcerr));
    check({tag, "_sender_mac"},  80'(arp_sender_mac), 80'(m_mac));
    check({tag, "_sender_ip"},   80'(arp_sender_ip),  80'(m_ip));
    check({tag, "_is_request"},  80'(arp_is_request), 80'(m_req));
    check({tag, "_pending"},     80'(sbq.size()),     80'(0));
  endtask

  initial begin
    logic [31:0] c;
    logic [63:0] r64;
    logic [47:0] dst, sha;
    logic [15:0] et, op;
    logic [31:0] tpa;
    int len, r;

    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end

    repeat (3) @(negedge clk);
    check("reset_arp_valid", 80'(arp_valid), 80'(0));
    check_state("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) drive(1'b0, 8'h00);

    // Valid reply to this station
    build(MY_MAC, 16'h0806, 16'd2, 48'h001122334455, 32'h0a001563, MY_IP, 64);
    send(0, 3);
    check_state("reply");

    // Same frame, corrupted SPA byte
    build(MY_MAC, 16'h0806, 16'd2, 48'h001122334455, 32'h0a001563, MY_IP, 64);
    frm[30] = frm[30] ^ 8'hFF;
    send(0, 3);
    check_state("crc_bad");

    // Broadcast requests: foreign TPA, then ours
    build(BCAST, 16'h0806, 16'd1, 48'h0a0b0c0d0e0f, 32'h0a001501, 32'h0a00154d, 64);
    send(0, 3);
    check_state("bc_other");
    build(BCAST, 16'h0806, 16'd1, 48'h0a0b0c0d0e0f, 32'h0a001501, MY_IP, 64);
    send(0, 3);
    check_state("bc_mine");

    // Broken preamble, then a runt
    build(MY_MAC, 16'h0806, 16'd2, 48'h111111111111, 32'h01020304, MY_IP, 64);
    send(1, 3);
    check_state("bad_pre");
    build(MY_MAC, 16'h0806, 16'd2, 48'h111111111111, 32'h01020304, MY_IP, 40);
    send(0, 3);
    check_state("runt40");

    // Back-to-back with a single idle cycle
    build(MY_MAC, 16'h0806, 16'd2, 48'h222222222222, 32'h0a000001, MY_IP, 64);
    send(0, 1);
    build(BCAST, 16'h0806, 16'd1, 48'h333333333333, 32'h0a000002, MY_IP, 64);
    send(0, 3);
    check_state("b2b");

    // Length and field boundaries
    build(MY_MAC, 16'h0806, 16'd2, 48'h444444444444, 32'h0a000003, MY_IP, 63);
    send(0, 3);
    check_state("len63");
    build(MY_MAC, 16'h0806, 16'd2, 48'h555555555555, 32'h0a000004, MY_IP, 1518);
    send(0, 3);
    check_state("len1518");
    build(MY_MAC, 16'h0806, 16'd2, 48'h666666666666, 32'h0a000005, MY_IP, 1519);
    send(0, 3);
    check_state("len1519");
    build(MY_MAC, 16'h0806, 16'd3, 48'h777777777777, 32'h0a000006, MY_IP, 64);
    send(0, 3);
    check_state("oper3");
    build(MY_MAC, 16'h0800, 16'd2, 48'h888888888888, 32'h0a000007, MY_IP, 64);
    send(0, 3);
    check_state("ipv4");

    // Reset asserted mid-frame and released while dv is still high
    build(MY_MAC, 16'h0806, 16'd2, 48'h999999999999, 32'h0a000008, MY_IP, 64);
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i <= 25; i++) drive(1'b1, frm[i]);
    #1 reset_n = 1'b0;
    #1;
    m_frames = '0; m_crcerr = '0; m_mac = '0; m_ip = '0; m_req = 1'b0;
    check("midrst_arp_valid", 80'(arp_valid), 80'(0));
    check_state("midrst");
    for (int i = 26; i <= 33; i++) drive(1'b1, frm[i]);
    @(negedge clk);
    dv = 1'b1;
    data = frm[34];
    reset_n = 1'b1;
    for (int i = 35; i < frm.size(); i++) drive(1'b1, frm[i]);
    repeat (3) drive(1'b0, 8'h00);
    check_state("post_rst");
    build(MY_MAC, 16'h0806, 16'd1, 48'hA1A2A3A4A5A6, 32'h0a0015fe, MY_IP, 64);
    send(0, 3);
    check_state("clean");

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 3);
      r64 = {$urandom, $urandom};
      dst = (r == 0) ? BCAST : (r == 3) ? r64[47:0] : MY_MAC;
      et = ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'h0806;
      r = $urandom_range(0, 5);
      op = (r < 2) ? 16'd1 : (r < 4) ? 16'd2 : (r == 4) ? 16'd0 : 16'h0101;
      tpa = ($urandom_range(0, 4) == 0) ? $urandom : MY_IP;
      r = $urandom_range(0, 7);
      len = (r == 0) ? $urandom_range(20, 63) : (r == 1) ? $urandom_range(65, 200) : 64;
      r64 = {$urandom, $urandom};
      sha = r64[47:0];
      build(dst, et, op, sha, $urandom, tpa, len);
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, frm.size() - 1);
        frm[r] = frm[r] ^ 8'($urandom_range(1, 255));
      end
      send(($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(2, 4));
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
